conv_encoder_framer: RTL and testbench
======================================

# conv_encoder_framer

Rate-1/2, constraint-length-3 convolutional encoder: the transmit-side counterpart of the team's 4-state hard-decision Viterbi decoder. It accepts a frame of FRAME_LEN information bits over a valid/ready handshake and emits one 2-bit code symbol per accepted bit. It then appends two zero tail bits so the trellis terminates in state 0. Symbols leave through a registered valid/ready output with start-of-frame and end-of-frame markers, suitable for driving the decoder's 2-bit encoded input directly.

## Interface
- FRAME_LEN, 16, information bits per frame; legal range 1..65535; bit counter width is clog2(FRAME_LEN+1).
- G0, 3'b111, generator polynomial for enc_out[1]; bit 2 taps the current input, bit 1 taps s1, bit 0 taps s0.
- G1, 3'b101, generator polynomial for enc_out[0]; same tap ordering as G0.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  reset; one clock; asynchronous and active-high.
- start  input  1  begin a frame; sampled only in IDLE.
- data_in  input  1  information bit.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  encoder accepts data_in this cycle.
- enc_out  output  2  code symbol, {G0 parity, G1 parity}.
- enc_valid  output  1  enc_out holds a symbol.
- enc_ready  input  1  downstream consumes the symbol this cycle.
- enc_sop  output  1  enc_out is the first symbol of a frame.
- enc_eop  output  1  enc_out is the last (second tail) symbol of a frame.
- busy  output  1  frame in progress or symbol pending.
- frame_done  output  1  one-cycle pulse when a frame completes.

## Operation
- Shift register {s1,s0}: s1 is the previous bit, s0 is the bit before it. On each encoded bit d: parity_k = ^(Gk & {d,s1,s0}); then s1<=d, s0<=s1.
- Output slot is free when !enc_valid || enc_ready.
- Handshake: a symbol transfers on enc_valid && enc_ready. data transfers on data_valid && data_ready.
- States:
  - IDLE: data_ready=0. On start, clear {s1,s0} and bit_cnt, go to DATA.
  - DATA: data_ready = slot free. Each accepted bit loads its symbol into the output register with enc_valid=1 and increments bit_cnt. The first bit of the frame sets enc_sop. Accepting bit FRAME_LEN goes to TAIL.
  - TAIL: data_ready=0. While the slot is free, encode d=0 and load the symbol. tail_cnt counts 0,1. The second tail symbol sets enc_eop and goes to DRAIN.
  - DRAIN: wait for the eop symbol transfer. On that transfer go to IDLE and pulse frame_done the next cycle.
- enc_valid clears on transfer when no new symbol is loaded in the same cycle. Simultaneous transfer and load is legal and yields back-to-back symbols.
- start outside IDLE is ignored. data_valid outside DATA is ignored, and no bit is consumed.
- busy = (state != IDLE) || enc_valid.
- At frame end the trellis state is always {s1,s0}=00.

## Timing
- Reset (asynchronous, active-high) drives the following, regardless of mid-frame activity; any partial frame is discarded:
  - state=IDLE
  - enc_out=2'b00
  - enc_valid=0, enc_sop=0, enc_eop=0
  - data_ready=0, busy=0, frame_done=0
  - {s1,s0}=00, bit_cnt=0, tail_cnt=0
- start at edge N puts the block in DATA, with data_ready=1 during cycle N+1.
- Latency is 1 cycle: a bit accepted at edge N appears on enc_out after edge N.
- With enc_ready held high, throughput is 1 symbol per cycle. A frame occupies FRAME_LEN+2 symbol cycles.
- While enc_valid=1 and enc_ready=0, enc_out, enc_sop and enc_eop hold stable and data_ready=0.
- frame_done is high for exactly one cycle, the cycle after the eop transfer.
- start in that same cycle (block in IDLE) is accepted.
- The minimum gap between frames is 2 cycles (eop transfer edge, then start edge).

## Test plan
- FRAME_LEN=4, G0=7, G1=5, enc_ready=1, bits 1,0,1,1 -> enc_out 11,10,00,01, then tail 01,11. enc_sop on the first symbol, enc_eop on the last. frame_done 1 cycle after the last transfer.
- Same frame with enc_ready toggling 1,0,0,1,... -> identical symbol sequence. Outputs are stable while stalled, and data_ready=0 whenever enc_valid && !enc_ready.
- FRAME_LEN=1, bit 1 -> 11, 10, 11 with sop on the first symbol and eop on the third. A bit 0 frame -> 00, 00, 00.
- Reset asserted mid-DATA after 2 bits -> all outputs 0 immediately. A new frame 1,0,1,1 then encodes from state 00 (11,10,00,01,01,11).
- start pulsed during DATA/TAIL/DRAIN -> ignored, frame length unchanged. data_valid in IDLE -> no symbol produced.
- Random 1000-bit frames looped through the team's Viterbi decoder with an error-free channel -> decoded bits match input after the decoder's fixed delay. Every frame ends at trellis state 00.

Source files
------------

// File: rtl/conv_encoder_framer.sv
// conv_encoder_framer: rate-1/2, K=3 convolutional encoder with frame framing.
// Accepts FRAME_LEN information bits, then appends two zero tail bits so the
// trellis returns to state 00. Emits one registered 2-bit symbol per bit with
// start/end-of-frame markers over a valid/ready output.
module conv_encoder_framer #(
    parameter int unsigned FRAME_LEN = 16,
    parameter logic [2:0]  G0        = 3'b111,
    parameter logic [2:0]  G1        = 3'b101
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [1:0] enc_out,
    output logic       enc_valid,
    input  logic       enc_ready,
    output logic       enc_sop,
    output logic       enc_eop,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned      CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_TAIL,
        ST_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       s_q, s_d;            // {s1, s0}
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             tail_cnt_q, tail_cnt_d;
    logic [1:0]       enc_out_q, enc_out_d;
    logic             enc_valid_q, enc_valid_d;
    logic             enc_sop_q, enc_sop_d;
    logic             enc_eop_q, enc_eop_d;
    logic             frame_done_q, frame_done_d;

    logic             slot_free;
    logic             xfer;
    logic             load;
    logic             enc_bit;
    logic [2:0]       taps;

    // Next-state, symbol-register and shift-register update.
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        bit_cnt_d    = bit_cnt_q;
        tail_cnt_d   = tail_cnt_q;
        enc_out_d    = enc_out_q;
        enc_valid_d  = enc_valid_q;
        enc_sop_d    = enc_sop_q;
        enc_eop_d    = enc_eop_q;
        frame_done_d = 1'b0;
        load         = 1'b0;
        enc_bit      = 1'b0;

        xfer      = enc_valid_q && enc_ready;
        slot_free = !enc_valid_q || enc_ready;

        // A transfer empties the slot; a load below in the same cycle refills it.
        if (xfer) begin
            enc_valid_d = 1'b0;
            enc_sop_d   = 1'b0;
            enc_eop_d   = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    s_d        = '0;
                    bit_cnt_d  = '0;
                    tail_cnt_d = 1'b0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (data_valid && slot_free) begin
                    load      = 1'b1;
                    enc_bit   = data_in;
                    enc_sop_d = (bit_cnt_q == '0);
                    enc_eop_d = 1'b0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        tail_cnt_d = 1'b0;
                        state_d    = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                if (slot_free) begin
                    load       = 1'b1;
                    enc_bit    = 1'b0;
                    enc_sop_d  = 1'b0;
                    enc_eop_d  = tail_cnt_q;
                    tail_cnt_d = tail_cnt_q + 1'b1;
                    if (tail_cnt_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (xfer && enc_eop_q) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        taps = {enc_bit, s_q};
        if (load) begin
            enc_out_d   = {^(G0 & taps), ^(G1 & taps)};
            enc_valid_d = 1'b1;
            s_d         = {enc_bit, s_q[1]};
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            s_q          <= '0;
            bit_cnt_q    <= '0;
            tail_cnt_q   <= 1'b0;
            enc_out_q    <= '0;
            enc_valid_q  <= 1'b0;
            enc_sop_q    <= 1'b0;
            enc_eop_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            bit_cnt_q    <= bit_cnt_d;
            tail_cnt_q   <= tail_cnt_d;
            enc_out_q    <= enc_out_d;
            enc_valid_q  <= enc_valid_d;
            enc_sop_q    <= enc_sop_d;
            enc_eop_q    <= enc_eop_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign data_ready = (state_q == ST_DATA) && slot_free;
    assign enc_out    = enc_out_q;
    assign enc_valid  = enc_valid_q;
    assign enc_sop    = enc_sop_q;
    assign enc_eop    = enc_eop_q;
    assign busy       = (state_q != ST_IDLE) || enc_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Bench for conv_encoder_framer: reference model computes each symbol as the
// convolution of the frame's bit sequence (with two appended zeros) against
// the generator polynomials, and a scoreboard matches symbols on transfer.
module tb_conv_encoder_framer;

    localparam int unsigned FL = 4;
    localparam logic [2:0]  G0 = 3'b111;
    localparam logic [2:0]  G1 = 3'b101;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       data_in = 1'b0;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic [1:0] enc_out;
    logic       enc_valid;
    logic       enc_ready = 1'b0;
    logic       enc_sop;
    logic       enc_eop;
    logic       busy;
    logic       frame_done;

    conv_encoder_framer #(.FRAME_LEN(FL), .G0(G0), .G1(G1)) dut (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .data_valid(data_valid), .data_ready(data_ready), .enc_out(enc_out),
        .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_sop(enc_sop),
        .enc_eop(enc_eop), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sym;
        logic       sop;
        logic       eop;
    } exp_t;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    exp_t        exp_q[$];
    bit          m_bits[$];
    bit          tx_q[$];
    logic [1:0]  sym_log[$];
    bit          m_in_frame = 0;
    int unsigned m_cnt = 0;
    int unsigned m_frames = 0;
    int unsigned fd_cnt = 0;
    bit          fd_exp = 0;
    bit          prev_stall = 0;
    logic [1:0]  prev_out;
    logic        prev_sop, prev_eop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Symbol for sequence index i: parity of generator taps over x[i], x[i-1], x[i-2].
    function automatic logic [1:0] ref_sym(input int i);
        logic [2:0] v;
        v[2] = m_bits[i];
        v[1] = (i >= 1) ? m_bits[i-1] : 1'b0;
        v[0] = (i >= 2) ? m_bits[i-2] : 1'b0;
        return {1'(($countones(G0 & v) % 2) == 1), 1'(($countones(G1 & v) % 2) == 1)};
    endfunction

    function automatic void model_accept(input bit b);
        exp_t e;
        m_bits.push_back(b);
        m_cnt++;
        e.sym = ref_sym(m_cnt - 1);
        e.sop = (m_cnt == 1);
        e.eop = 1'b0;
        exp_q.push_back(e);
        if (m_cnt == FL) begin
            m_bits.push_back(1'b0);
            m_bits.push_back(1'b0);
            for (int k = 0; k < 2; k++) begin
                e.sym = ref_sym(FL + k);
                e.sop = 1'b0;
                e.eop = (k == 1);
                exp_q.push_back(e);
            end
        end
    endfunction

    function automatic void model_flush();
        exp_q.delete();
        m_bits.delete();
        tx_q.delete();
        m_in_frame = 0;
        m_cnt      = 0;
        fd_exp     = 0;
        prev_stall = 0;
    endfunction

    // One clock cycle: observe outputs, score any transfer, then drive inputs.
    task automatic tick(input int unsigned rdy_pct, input int unsigned dv_pct, input bit do_start);
        bit   eop_x;
        exp_t e;
        @(negedge clk);
        enc_ready = ($urandom_range(99) < rdy_pct);
        #1;
        check("frame_done", frame_done, fd_exp);
        if (frame_done) fd_cnt++;
        check("data_ready", data_ready,
              m_in_frame && (m_cnt < FL) && (!enc_valid || enc_ready));
        check("busy", busy, m_in_frame || enc_valid);
        if (prev_stall) begin
            check("hold_out", enc_out, prev_out);
            check("hold_sop", enc_sop, prev_sop);
            check("hold_eop", enc_eop, prev_eop);
        end
        eop_x = 0;
        if (enc_valid && enc_ready) begin
            if (exp_q.size() == 0) begin
                check("sym_extra", {enc_valid, enc_out}, 0);
            end else begin
                e = exp_q.pop_front();
                check("sym", enc_out, e.sym);
                check("sop", enc_sop, e.sop);
                check("eop", enc_eop, e.eop);
                sym_log.push_back(enc_out);
                eop_x = e.eop;
            end
        end
        prev_stall = enc_valid && !enc_ready;
        prev_out   = enc_out;
        prev_sop   = enc_sop;
        prev_eop   = enc_eop;

        start = do_start;
        if (do_start && !m_in_frame) begin
            m_in_frame = 1;
            m_cnt      = 0;
            m_bits.delete();
        end
        data_valid = ($urandom_range(99) < dv_pct);
        data_in    = (tx_q.size() != 0) ? tx_q[0] : 1'($urandom_range(1));
        if (data_valid && data_ready) begin
            if (tx_q.size() != 0) void'(tx_q.pop_front());
            model_accept(data_in);
        end
        if (eop_x) begin
            m_in_frame = 0;
            m_frames++;
        end
        fd_exp = eop_x;
    endtask

    task automatic run_until_idle(input int unsigned rdy_pct, input string tag);
        int unsigned n = 0;
        while ((m_in_frame || enc_valid) && n < 200) begin
            tick(rdy_pct, 100, 0);
            n++;
        end
        check(tag, {m_in_frame, enc_valid}, 0);
        tick(rdy_pct, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out"}, enc_out, 0);
        check({tag, "_valid"}, enc_valid, 0);
        check({tag, "_sop"}, enc_sop, 0);
        check({tag, "_eop"}, enc_eop, 0);
        check({tag, "_dready"}, data_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fdone"}, frame_done, 0);
    endtask

    task automatic directed_frame(input int unsigned rdy_pct, input string tag);
        logic [1:0] dir_exp [6];
        dir_exp = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        sym_log.delete();
        tx_q = '{1'b1, 1'b0, 1'b1, 1'b1};
        tick(rdy_pct, 100, 1);
        run_until_idle(rdy_pct, {tag, "_timeout"});
        check({tag, "_len"}, sym_log.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < sym_log.size()) check({tag, "_sym"}, sym_log[k], dir_exp[k]);
        end
    endtask

    initial begin
        #1;
        check_reset_outputs("rst0");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        directed_frame(100, "dir_full");
        directed_frame(45, "dir_stall");

        // data_valid with no frame open: no symbols, block stays idle.
        for (int i = 0; i < 6; i++) tick(100, 100, 0);

        // Reset after two accepted bits discards the partial frame.
        tx_q = '{1'b1, 1'b0, 1'b1, 1'b1};
        tick(100, 100, 1);
        for (int i = 0; i < 20 && m_cnt < 2; i++) tick(100, 100, 0);
        check("mid_bits", m_cnt, 2);
        @(posedge clk);
        #2;
        start      = 1'b0;
        data_valid = 1'b0;
        reset      = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        model_flush();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        directed_frame(100, "dir_after_rst");

        // Random traffic: random stalls, gaps, bits, and stray start pulses.
        for (int i = 0; i < 3000; i++) tick(70, 70, $urandom_range(7) == 0);
        run_until_idle(100, "rand_timeout");
        check("frame_count", fd_cnt, m_frames);
        check("exp_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
